life_step_ctrl: RTL and testbench

- Owns the Game of Life cell array and sequences generation updates.
- Drives the flat cell vector consumed by the VGA grid renderer.
- Computes the next generation serially, one cell per clock, into a shadow buffer. Commits it only on a frame boundary so the display never tears.
- Supports run/pause at a programmable frame rate, single-step, and seed loading.

---
 rtl/life_step_ctrl_if.sv | 34 +++
 rtl/life_step_ctrl.sv | 139 +++++++++++++
 tb/tb_life_step_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/life_step_ctrl_if.sv
// Control/data bundle between the Game of Life step controller and its
// environment (frame timing source, user controls, seed source, renderer).
//   frame_tick : one-cycle pulse at start of vertical blanking
//   run        : level, free-running generations
//   step       : one-cycle pulse, single generation request while paused
//   seed_load  : one-cycle pulse, copy seed into the live array
//   seed       : seed pattern, bit ordering as cells
//   cells      : live array, cells[row*COLS+col], 1 = alive
//   busy       : generation computing or awaiting commit
//   gen_count  : committed generations since reset/seed
interface life_step_ctrl_if #(
  parameter int COLS  = 64,
  parameter int ROWS  = 48,
  parameter int GEN_W = 16
);
  logic                    frame_tick;
  logic                    run;
  logic                    step;
  logic                    seed_load;
  logic [0:COLS*ROWS-1]    seed;
  logic [0:COLS*ROWS-1]    cells;
  logic                    busy;
  logic [GEN_W-1:0]        gen_count;

  modport master (
    output frame_tick, run, step, seed_load, seed,
    input  cells, busy, gen_count
  );

  modport slave (
    input  frame_tick, run, step, seed_load, seed,
    output cells, busy, gen_count
  );
endinterface

// File: rtl/life_step_ctrl.sv
// Game of Life array owner and generation sequencer.
// The live array drives the renderer directly; the next generation is
// computed serially (one cell per clock) into a shadow buffer and committed
// only on a frame_tick so the display never tears.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : life_step_ctrl_if slave (controls, seed, cells, busy, gen_count)
module life_step_ctrl #(
  parameter int COLS     = 64,
  parameter int ROWS     = 48,
  parameter int RATE_DIV = 8,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  life_step_ctrl_if.slave   bus
);
  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);
  localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, WAIT_COMMIT} state_t;

  state_t           state, state_n;
  logic [0:N-1]     cur, nxt;
  logic [IW-1:0]    index;
  logic [RB-1:0]    row;
  logic [CB-1:0]    col;
  logic [RW-1:0]    rate;
  logic [GEN_W-1:0] gen;

  logic load_seed, start, commit, rate_inc, rate_clr, last_cell;
  logic [RB-1:0] rm, rp;
  logic [CB-1:0] cm, cp;
  logic [3:0]    nbr;
  logic          alive;

  function automatic logic [IW-1:0] addr(input logic [RB-1:0] r, input logic [CB-1:0] c);
    return IW'(r) * IW'(COLS) + IW'(c);
  endfunction

  assign bus.cells     = cur;
  assign bus.gen_count = gen;
  assign bus.busy      = (state == COMPUTE) || (state == WAIT_COMMIT);
  assign last_cell     = (index == IW'(N - 1));

  // Toroidal neighbourhood of the cell at (row, col).
  always_comb begin
    rm  = (row == '0) ? RB'(ROWS - 1) : row - 1'b1;
    rp  = (row == RB'(ROWS - 1)) ? '0 : row + 1'b1;
    cm  = (col == '0) ? CB'(COLS - 1) : col - 1'b1;
    cp  = (col == CB'(COLS - 1)) ? '0 : col + 1'b1;
    nbr = 4'(cur[addr(rm, cm)]) + 4'(cur[addr(rm, col)]) + 4'(cur[addr(rm, cp)]) +
          4'(cur[addr(row, cm)])                          + 4'(cur[addr(row, cp)]) +
          4'(cur[addr(rp, cm)]) + 4'(cur[addr(rp, col)]) + 4'(cur[addr(rp, cp)]);
    alive = (nbr == 4'd3) || ((nbr == 4'd2) && cur[index]);
  end

  always_comb begin
    state_n   = state;
    load_seed = 1'b0;
    start     = 1'b0;
    commit    = 1'b0;
    rate_inc  = 1'b0;
    rate_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.seed_load) begin
          load_seed = 1'b1;
        end else if (!bus.run) begin
          rate_clr = 1'b1;
          start    = bus.step;
        end else if (bus.frame_tick) begin
          if (rate == RW'(RATE_DIV - 1)) begin
            rate_clr = 1'b1;
            start    = 1'b1;
          end else begin
            rate_inc = 1'b1;
          end
        end
        if (start) state_n = COMPUTE;
      end
      COMPUTE: begin
        if (last_cell) state_n = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (bus.frame_tick) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      nxt   <= '0;
      index <= '0;
      row   <= '0;
      col   <= '0;
      rate  <= '0;
      gen   <= '0;
    end else begin
      state <= state_n;
      if (load_seed) begin
        cur <= bus.seed;
        gen <= '0;
      end
      if (commit) begin
        cur <= nxt;
        gen <= gen + 1'b1;
      end
      if (rate_clr)      rate <= '0;
      else if (rate_inc) rate <= rate + 1'b1;
      // row/col track index so the neighbourhood needs no divider.
      if (state == COMPUTE) begin
        nxt[index] <= alive;
        if (last_cell) begin
          index <= '0;
          row   <= '0;
          col   <= '0;
        end else begin
          index <= index + 1'b1;
          if (col == CB'(COLS - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_life_step_ctrl.sv
module tb_life_step_ctrl;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int RATE_DIV = 2;
  localparam int GEN_W = 16;
  localparam int N = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  life_step_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .GEN_W(GEN_W)) bus ();

  life_step_ctrl #(.COLS(COLS), .ROWS(ROWS), .RATE_DIV(RATE_DIV), .GEN_W(GEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [0:N-1] pat(input int a = -1, input int b = -1,
                                       input int c = -1, input int d = -1);
    logic [0:N-1] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (i == a || i == b || i == c || i == d) v[i] = 1'b1;
    return v;
  endfunction

  // Whole-grid next generation from the rules, toroidal wrap.
  function automatic logic [0:N-1] life_next(input logic [0:N-1] g);
    logic [0:N-1] o;
    int cnt;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(g[((r + dr + ROWS) % ROWS) * COLS + (c + dc + COLS) % COLS]);
        o[r * COLS + c] = (cnt == 3) || (cnt == 2 && g[r * COLS + c]);
      end
    return o;
  endfunction

  // Reference model: a generation is a block of N busy cycles followed by a
  // wait for frame_tick, with its result taken in one go from the live grid.
  logic [0:N-1]     m_cells = '0;
  logic [0:N-1]     m_pend  = '0;
  logic [GEN_W-1:0] m_gen   = '0;
  logic             m_busy  = 1'b0;
  int               m_left  = 0;
  int               m_rate  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cells = '0; m_pend = '0; m_gen = '0; m_busy = 1'b0; m_left = 0; m_rate = 0;
    end else if (!m_busy) begin
      if (bus.seed_load) begin
        m_cells = bus.seed;
        m_gen   = '0;
      end else if (!bus.run) begin
        m_rate = 0;
        if (bus.step) begin
          m_busy = 1'b1; m_left = N; m_pend = life_next(m_cells);
        end
      end else if (bus.frame_tick) begin
        if (m_rate == RATE_DIV - 1) begin
          m_rate = 0;
          m_busy = 1'b1; m_left = N; m_pend = life_next(m_cells);
        end else begin
          m_rate++;
        end
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (bus.frame_tick) begin
      m_cells = m_pend;
      m_gen   = m_gen + 1'b1;
      m_busy  = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_cells", 64'(bus.cells), 64'(m_cells));
    chk("model_busy", 64'(bus.busy), 64'(m_busy));
    chk("model_gen", 64'(bus.gen_count), 64'(m_gen));
  end

  task automatic do_idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_step();
    @(posedge clk); #2 bus.step = 1'b1;
    @(posedge clk); #2 bus.step = 1'b0;
  endtask

  task automatic do_tick();
    @(posedge clk); #2 bus.frame_tick = 1'b1;
    @(posedge clk); #2 bus.frame_tick = 1'b0;
  endtask

  task automatic do_seed(input logic [0:N-1] p);
    @(posedge clk); #2 bus.seed = p; bus.seed_load = 1'b1;
    @(posedge clk); #2 bus.seed_load = 1'b0;
  endtask

  logic [0:N-1] blk;
  bit   busy_after [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int   gen_after  [6] = '{0, 0, 1, 1, 1, 2};

  initial begin
    bus.frame_tick = 1'b0;
    bus.run        = 1'b0;
    bus.step       = 1'b0;
    bus.seed_load  = 1'b0;
    bus.seed       = '0;
    #3;
    chk("reset_cells", 64'(bus.cells), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_gen", 64'(bus.gen_count), 64'(0));
    do_idle(3);
    rst_n = 1'b1;
    do_idle(2);

    // Blinker, horizontal -> vertical
    do_seed(pat(19, 20, 21));
    chk("blink_seed", 64'(bus.cells), 64'(pat(19, 20, 21)));
    do_step();
    chk("blink_busy_rise", 64'(bus.busy), 64'(1));
    do_idle(60);
    chk("blink_busy_wait", 64'(bus.busy), 64'(1));
    chk("blink_no_tear", 64'(bus.cells), 64'(pat(19, 20, 21)));
    do_tick();
    chk("blink_cells", 64'(bus.cells), 64'(pat(12, 20, 28)));
    chk("blink_gen", 64'(bus.gen_count), 64'(1));
    chk("blink_busy_fall", 64'(bus.busy), 64'(0));

    // Vertical blinker on column 0 wraps to columns 7,0,1 of row 2
    do_seed(pat(8, 16, 24));
    chk("wrap_gen_clear", 64'(bus.gen_count), 64'(0));
    do_step();
    do_idle(55);
    do_tick();
    chk("wrap_cells", 64'(bus.cells), 64'(pat(16, 17, 23)));
    chk("wrap_gen", 64'(bus.gen_count), 64'(1));

    // Still life with rate divider; the commit tick is not counted
    blk = pat(0, 1, 8, 9);
    do_seed(blk);
    bus.run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_idle(70);
      do_tick();
      chk($sformatf("rate_busy_t%0d", k + 1), 64'(bus.busy), 64'(busy_after[k]));
      chk($sformatf("rate_gen_t%0d", k + 1), 64'(bus.gen_count), 64'(gen_after[k]));
      chk($sformatf("rate_cells_t%0d", k + 1), 64'(bus.cells), 64'(blk));
    end
    bus.run = 1'b0;
    do_idle(3);

    // A: seed_load beats step
    @(posedge clk); #2 bus.seed = pat(1, 2, 3); bus.seed_load = 1'b1; bus.step = 1'b1;
    @(posedge clk); #2 bus.seed_load = 1'b0; bus.step = 1'b0;
    chk("prio_cells", 64'(bus.cells), 64'(pat(1, 2, 3)));
    chk("prio_busy", 64'(bus.busy), 64'(0));
    do_idle(3);
    chk("prio_busy_later", 64'(bus.busy), 64'(0));

    // B: step during COMPUTE ignored
    do_step();
    do_idle(10);
    do_step();
    do_idle(50);
    do_tick();
    chk("ign_step_gen", 64'(bus.gen_count), 64'(1));
    do_idle(10);
    chk("ign_step_busy", 64'(bus.busy), 64'(0));
    chk("ign_step_cells", 64'(bus.cells), 64'(pat(2, 10, 42)));

    // C: seed_load during WAIT_COMMIT ignored
    do_step();
    do_idle(55);
    do_seed(pat(0));
    chk("ign_seed_cells", 64'(bus.cells), 64'(pat(2, 10, 42)));
    chk("ign_seed_busy", 64'(bus.busy), 64'(1));
    do_tick();
    chk("ign_seed_commit", 64'(bus.cells), 64'(pat(1, 2, 3)));
    chk("ign_seed_gen", 64'(bus.gen_count), 64'(2));

    // Reset twenty cycles into COMPUTE
    do_step();
    do_idle(20);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cells", 64'(bus.cells), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_gen", 64'(bus.gen_count), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    do_step();
    do_idle(55);
    do_tick();
    chk("rst_after_cells", 64'(bus.cells), 64'(0));
    chk("rst_after_gen", 64'(bus.gen_count), 64'(1));
    chk("rst_after_busy", 64'(bus.busy), 64'(0));
    do_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
